// File: rtl/fir_coeff_loader_pkg.sv
// Shared types and helpers for the MSO FIR coefficient loader.
package fir_coeff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } load_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_coeff_loader_bank.sv
// Shadow/active coefficient storage with atomic commit and registered readback.
module fir_coeff_bank
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter logic [N*COEFF_WIDTH-1:0] RESET_COEFFS = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [IDX_WIDTH-1:0]     wr_idx_i,
    input  logic [COEFF_WIDTH-1:0]   wr_data_i,
    input  logic                     commit_i,
    input  logic [IDX_WIDTH-1:0]     rd_index_i,
    output logic [N*COEFF_WIDTH-1:0] packed_coeffs_o,
    output logic                     coeffs_updated_o,
    output logic [COEFF_WIDTH-1:0]   rd_coeff_o
);

    logic [COEFF_WIDTH-1:0]   shadow_q [N];
    logic [N*COEFF_WIDTH-1:0] shadow_packed;
    logic [N*COEFF_WIDTH-1:0] active_q;
    logic                     updated_q;
    logic [COEFF_WIDTH-1:0]   rd_coeff_q;
    logic [COEFF_WIDTH-1:0]   rd_coeff_d;

    always_comb begin
        shadow_packed = '0;
        for (int unsigned t = 0; t < N; t++) begin
            shadow_packed[COEFF_WIDTH*t +: COEFF_WIDTH] = shadow_q[t];
        end
    end

    // Indices with no matching tap (rd_index >= N) fall through to zero.
    always_comb begin
        rd_coeff_d = '0;
        for (int unsigned t = 0; t < N; t++) begin
            if (rd_index_i == IDX_WIDTH'(t)) begin
                rd_coeff_d = active_q[COEFF_WIDTH*t +: COEFF_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < N; t++) begin
                shadow_q[t] <= '0;
            end
            active_q   <= RESET_COEFFS;
            updated_q  <= 1'b0;
            rd_coeff_q <= '0;
        end else begin
            for (int unsigned t = 0; t < N; t++) begin
                if (wr_en_i && (wr_idx_i == IDX_WIDTH'(t))) begin
                    shadow_q[t] <= wr_data_i;
                end
            end
            if (commit_i) begin
                active_q <= shadow_packed;
            end
            updated_q  <= commit_i;
            rd_coeff_q <= rd_coeff_d;
        end
    end

    assign packed_coeffs_o  = active_q;
    assign coeffs_updated_o = updated_q;
    assign rd_coeff_o       = rd_coeff_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams coefficient frames into a shadow bank and commits complete frames atomically.
module fir_coeff_loader
    import fir_coeff_loader_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter logic [N*COEFF_WIDTH-1:0] RESET_COEFFS = '0,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [COEFF_WIDTH-1:0]   s_data,
    input  logic                     s_last,
    input  logic                     commit_en,
    output logic [N*COEFF_WIDTH-1:0] packed_coeffs,
    output logic                     coeffs_updated,
    output logic                     frame_error,
    input  logic [IDX_WIDTH-1:0]     rd_index,
    output logic [COEFF_WIDTH-1:0]   rd_coeff
);

    if (N < 1) begin : g_bad_n
        $error("fir_coeff_loader: N must be >= 1");
    end
    if ((IDX_WIDTH < 1) || (IDX_WIDTH < clog2(N))) begin : g_bad_idx
        $error("fir_coeff_loader: IDX_WIDTH too small for N taps");
    end

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    load_state_e            state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   ready_q, ready_d;
    logic                   ferr_q, ferr_d;
    logic                   xfer;
    logic                   wr_en;
    logic [IDX_WIDTH-1:0]   wr_idx;
    logic                   commit;

    assign xfer = s_valid && ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ferr_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    idx_d  = IDX_WIDTH'(1);
                    if ((N == 1) && s_last) begin
                        state_d = ST_COMMIT;
                    end else if (s_last) begin
                        ferr_d = 1'b1;
                        idx_d  = '0;
                    end else if (N == 1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (s_last && (idx_q == LAST_IDX)) begin
                        state_d = ST_COMMIT;
                    end else if (s_last) begin
                        ferr_d  = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && s_last) begin
                    ferr_d  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (commit_en) begin
                    commit  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d != ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
        end
    end

    assign s_ready     = ready_q;
    assign frame_error = ferr_q;

    fir_coeff_bank #(
        .N            (N),
        .COEFF_WIDTH  (COEFF_WIDTH),
        .IDX_WIDTH    (IDX_WIDTH),
        .RESET_COEFFS (RESET_COEFFS)
    ) u_bank (
        .clk              (clk),
        .rst              (rst),
        .wr_en_i          (wr_en),
        .wr_idx_i         (wr_idx),
        .wr_data_i        (s_data),
        .commit_i         (commit),
        .rd_index_i       (rd_index),
        .packed_coeffs_o  (packed_coeffs),
        .coeffs_updated_o (coeffs_updated),
        .rd_coeff_o       (rd_coeff)
    );

endmodule
